// File: rtl/module34_split_if.sv
// module34_split_if: bundles the input stream and the four branch streams of
// the splitter.
//   s_data/s_valid/s_ready    : 2*dw-bit input stream
//   a,b,c,d (+_valid/_ready)  : dw-bit branch streams (lo, hi, lo+hi, lo-hi)
// slave  : the splitter's view (consumes s_*, produces branches)
// master : the environment's view (produces s_*, consumes branches)
interface module34_split_if #(parameter int dw = 8);
  logic [2*dw-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic [dw-1:0]   a, b, c, d;
  logic            a_valid, b_valid, c_valid, d_valid;
  logic            a_ready, b_ready, c_ready, d_ready;

  modport slave (
    input  s_data, s_valid, a_ready, b_ready, c_ready, d_ready,
    output s_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid
  );

  modport master (
    output s_data, s_valid, a_ready, b_ready, c_ready, d_ready,
    input  s_ready, a, b, c, d, a_valid, b_valid, c_valid, d_valid
  );
endinterface

// File: rtl/module34_split.sv
// module34_split: one 2*dw-bit valid/ready stream fanned out to four dw-bit
// valid/ready branches (lo, hi, lo+hi, lo-hi, all mod 2^dw). A word is taken
// only when every branch can accept it; branches drain independently.
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   io       : module34_split_if.slave (input stream + branches a..d)
//   word_cnt : words accepted since reset, wraps at 16 bits

// One branch: output register plus valid flag.
module module34_split_lane #(parameter int dw = 8) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [dw-1:0] din,
  input  logic          ready,
  output logic [dw-1:0] data,
  output logic          valid,
  output logic          free
);
  // An empty branch is free even with ready low.
  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // Reload wins over a same-edge drain: valid stays up with new data.
      data  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module module34_split #(parameter int dw = 8) (
  input  logic           clk,
  input  logic           reset,
  module34_split_if.slave io,
  output logic [15:0]    word_cnt
);
  localparam int NUM_LANES = 4;

  logic [dw-1:0]                 lo, hi, sum, dif;
  logic [NUM_LANES-1:0][dw-1:0]  din, data;
  logic [NUM_LANES-1:0]          rdy, vld, free;
  logic                          accept;

  assign lo  = io.s_data[dw-1:0];
  assign hi  = io.s_data[2*dw-1:dw];
  assign sum = lo + hi;
  assign dif = lo - hi;

  assign din = {dif, sum, hi, lo};
  assign rdy = {io.d_ready, io.c_ready, io.b_ready, io.a_ready};

  // Independent of s_valid so upstream may wait on s_ready.
  assign io.s_ready = reset && (&free);
  assign accept     = io.s_valid && io.s_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    module34_split_lane #(.dw(dw)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .din   (din[i]),
      .ready (rdy[i]),
      .data  (data[i]),
      .valid (vld[i]),
      .free  (free[i])
    );
  end

  assign io.a = data[0];
  assign io.b = data[1];
  assign io.c = data[2];
  assign io.d = data[3];
  assign io.a_valid = vld[0];
  assign io.b_valid = vld[1];
  assign io.c_valid = vld[2];
  assign io.d_valid = vld[3];

  always_ff @(posedge clk) begin
    if (!reset)      word_cnt <= '0;
    else if (accept) word_cnt <= word_cnt + 16'd1;
  end
endmodule
